// File: rtl/uart_pkg.sv
// Shared UART types and constants for uart_tx_scheduler and its round-robin arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Bit periods per frame: start + payload + optional parity + stop.
  function automatic int unsigned uart_frame_len(input int unsigned data_w,
                                                 input bit          parity_en);
    return data_w + 32'd2 + (parity_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request after 'last', wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         win,
  output logic [$clog2(NUM_REQ)-1:0] win_id
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_id   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART tx line between NUM_REQ byte requesters.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       baud_tick,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       tx
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  uart_state_e        state;
  logic [DATA_W-1:0]  shift;
  logic [DATA_W-1:0]  shift_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [ID_W-1:0]    last;
  logic [NUM_REQ-1:0] win;
  logic [ID_W-1:0]    win_id;
  logic [DATA_W-1:0]  win_data;
  logic               accept;
`ifdef UART_TX_PARITY_EN
  logic               parity;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .last   (last),
    .win    (win),
    .win_id (win_id)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_data = data[i*DATA_W +: DATA_W];
    end
  end

  assign shift_nxt = shift >> 1;

  // A new frame may start from IDLE or directly on the closing stop tick.
  assign accept = baud_tick && (req != '0) && ((state == IDLE) || (state == STOP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      last       <= ID_W'(NUM_REQ - 1);
      active_id  <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tx         <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      gnt        <= '0;
      frame_done <= 1'b0;
      if (accept) begin
        if (state == STOP) frame_done <= 1'b1;
        shift     <= win_data;
        last      <= win_id;
        active_id <= win_id;
        gnt       <= win;
        busy      <= 1'b1;
        tx        <= UART_START_LVL;
        state     <= START;
`ifdef UART_TX_PARITY_EN
        parity    <= ^win_data;
`endif
      end else if (baud_tick) begin
        unique case (state)
          IDLE: begin
            tx <= UART_IDLE_LVL;
          end
          START: begin
            tx      <= shift[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= UART_IDLE_LVL;
              state <= STOP;
`endif
            end else begin
              shift   <= shift_nxt;
              tx      <= shift_nxt[0];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            tx    <= UART_IDLE_LVL;
            state <= STOP;
          end
          STOP: begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            tx         <= UART_IDLE_LVL;
            state      <= IDLE;
          end
          default: begin
            tx    <= UART_IDLE_LVL;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: grant scoreboard plus per-tick frame capture.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BAUD_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int unsigned FRAME_LEN = DATA_W + 2 + (PAR_EN ? 1 : 0);

  logic                      clk;
  logic                      rst_n;
  logic                      baud_tick;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        gnt;
  logic [1:0]                active_id;
  logic                      busy;
  logic                      frame_done;
  logic                      tx;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .req        (req),
    .data       (data),
    .gnt        (gnt),
    .active_id  (active_id),
    .busy       (busy),
    .frame_done (frame_done),
    .tx         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick updates 1ns after the falling edge, so at each falling edge baud_tick
  // shows whether the rising edge just passed was a tick edge.
  int unsigned div_cnt;
  initial begin
    baud_tick = 1'b0;
    div_cnt   = 0;
    forever begin
      @(negedge clk);
      #1;
      div_cnt   = (div_cnt + 1) % BAUD_DIV;
      baud_tick = (div_cnt == 0);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned       id;
    logic [DATA_W-1:0] d;
  } exp_t;
  exp_t sb[$];

  function automatic logic [FRAME_LEN-1:0] frame_bits(input logic [DATA_W-1:0] d);
    logic [FRAME_LEN-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < DATA_W; i++) b[1+i] = d[i];
    if (PAR_EN) b[DATA_W+1] = ^d;
    b[FRAME_LEN-1] = 1'b1;
    return b;
  endfunction

  // Monitor state
  bit                   capturing = 0;
  int unsigned          bit_idx   = 0;
  logic [FRAME_LEN-1:0] cap_bits;
  logic [FRAME_LEN-1:0] exp_frame;
  logic                 prev_tx   = 1'b1;
  int unsigned          tick_cnt  = 0;
  int unsigned          prev_tick = 0;
  bit                   prev_valid = 0;
  bit                   check_gap  = 0;
  exp_t                 mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      capturing  = 0;
      bit_idx    = 0;
      prev_valid = 0;
    end else begin
      if (baud_tick && capturing) begin
        cap_bits[bit_idx] = prev_tx;
        bit_idx++;
        if (bit_idx == FRAME_LEN) begin
          capturing = 0;
          chk("frame_bits", 32'(cap_bits), 32'(exp_frame));
          chk("frame_done", 32'(frame_done), 32'd1);
        end else begin
          chk("busy_in_frame", 32'(busy), 32'd1);
        end
      end else if (frame_done) begin
        chk("frame_done_spurious", 32'(frame_done), 32'd0);
      end
      if (gnt != '0) begin
        chk("gnt_after_tick", 32'(baud_tick), 32'd1);
        if (capturing) chk("gnt_overlap", 32'(bit_idx), 32'(FRAME_LEN));
        if (sb.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("gnt_onehot", 32'(gnt), 32'd1 << mon_e.id);
          chk("active_id", 32'(active_id), mon_e.id);
          chk("busy_at_gnt", 32'(busy), 32'd1);
          chk("tx_start", 32'(tx), 32'd0);
          exp_frame = frame_bits(mon_e.d);
          capturing = 1;
          bit_idx   = 0;
          if (check_gap && prev_valid) chk("gnt_gap_ticks", tick_cnt - prev_tick, FRAME_LEN);
          prev_tick  = tick_cnt;
          prev_valid = 1;
        end
      end
    end
    if (baud_tick) tick_cnt++;
    prev_tx = tx;
  end

  task automatic push(input int unsigned id);
    exp_t e;
    e.id = id;
    e.d  = data[id*DATA_W +: DATA_W];
    sb.push_back(e);
  endtask

  task automatic run_grants(input int unsigned n, input bit hold);
    int unsigned got = 0;
    int unsigned cyc = 0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        got++;
        if (!hold) req = req & ~gnt;
      end
    end
    if (got < n) chk("grant_timeout", got, n);
  endtask

  task automatic wait_ticks(input int unsigned n);
    int unsigned k = 0;
    int unsigned cyc = 0;
    while (k < n && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (baud_tick) k++;
    end
  endtask

  task automatic wait_idle();
    int unsigned cyc = 0;
    @(negedge clk);
    while (busy && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    wait_ticks(2);
    chk("sb_empty", sb.size(), 32'd0);
    chk("tx_idle", 32'(tx), 32'd1);
  endtask

  task automatic rand_data();
    for (int unsigned i = 0; i < NUM_REQ; i++) data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    int unsigned        n;
    int unsigned        ids [4];
  } vec_t;
  vec_t vecs [5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Order expectations assume 'last' = 2 entering the table.
    vecs[0] = '{mask: 4'b1111, n: 4, ids: '{3, 0, 1, 2}};
    vecs[1] = '{mask: 4'b1010, n: 2, ids: '{3, 1, 0, 0}};
    vecs[2] = '{mask: 4'b0101, n: 2, ids: '{2, 0, 0, 0}};
    vecs[3] = '{mask: 4'b1001, n: 2, ids: '{3, 0, 0, 0}};
    vecs[4] = '{mask: 4'b0011, n: 2, ids: '{1, 0, 0, 0}};

    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_vals", {tx, busy, frame_done, gnt, active_id}, {1'b1, 1'b1 ^ 1'b1, 1'b0, 4'b0000, 2'd0});
    rst_n = 1'b1;

    // Idle: 50 ticks with no requests
    for (int unsigned t = 0; t < 50; t++) begin
      wait_ticks(1);
      chk("idle", {tx, busy, frame_done, gnt}, {1'b1, 1'b0, 1'b0, 4'b0000});
    end

    // Fairness: requests held continuously, reset leaves last=3 so 0 wins first
    rand_data();
    req = 4'b1111;
    for (int unsigned k = 0; k < 8; k++) push(k % NUM_REQ);
    check_gap  = 1;
    prev_valid = 0;
    run_grants(8, 1'b1);
    req = '0;
    wait_idle();
    check_gap = 0;

    // Single frame from requester 2, payload 0xA5
    rand_data();
    data[2*DATA_W +: DATA_W] = 8'hA5;
    wait_ticks(1);
    @(negedge clk);
    req = 4'b0100;
    push(2);
    run_grants(1, 1'b0);
    wait_idle();
    chk("active_id_hold", 32'(active_id), 32'd2);

    // Table of simultaneous request masks
    for (int unsigned v = 0; v < 5; v++) begin
      rand_data();
      req = vecs[v].mask;
      for (int unsigned k = 0; k < vecs[v].n; k++) push(vecs[v].ids[k]);
      run_grants(vecs[v].n, 1'b0);
      wait_idle();
    end

    // Late request: req[1] mid-frame of requester 3, req[0] only after gnt[1]
    rand_data();
    check_gap  = 1;
    prev_valid = 0;
    req = 4'b1000;
    push(3);
    run_grants(1, 1'b0);
    wait_ticks(4);
    req[1] = 1'b1;
    push(1);
    run_grants(1, 1'b0);
    req[0] = 1'b1;
    push(0);
    run_grants(1, 1'b0);
    wait_idle();
    check_gap = 0;

    // Reset mid-frame: requester 0 wins, abort in DATA bit 4
    rand_data();
    req = 4'b0001;
    push(0);
    run_grants(1, 1'b0);
    wait_ticks(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_outs", {busy, frame_done, gnt}, 6'd0);
    repeat (2 * BAUD_DIV) begin
      @(negedge clk);
      chk("rst_hold", {tx, busy, frame_done, gnt, active_id}, {1'b1, 1'b0, 1'b0, 4'b0000, 2'd0});
    end
    rst_n = 1'b1;
    rand_data();
    req = 4'b1111;
    for (int unsigned k = 0; k < 4; k++) push(k);
    run_grants(4, 1'b0);
    wait_idle();

    if (PAR_EN) begin
      // Parity payload 0x07: three ones, parity bit 1
      data[0 +: DATA_W] = 8'h07;
      req = 4'b0001;
      push(0);
      run_grants(1, 1'b0);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmit line between `NUM_REQ` byte requesters and sequences the serial frame using the system baud tick. It sits between the baud-rate generator, which supplies a one-cycle `baud_tick` every bit period, and the pad-level `tx` line. It arbitrates only on bit boundaries, so every start bit is exactly one bit period long.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `DATA_W`, default 8: bits per frame payload.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `baud_tick` in 1: one-cycle pulse per bit period, never high on two consecutive cycles.
- `req` in `NUM_REQ`: per-requester request; held high until the matching `gnt`.
- `data` in `NUM_REQ*DATA_W`: flattened payloads; slice i is `data[i*DATA_W +: DATA_W]`; stable while `req[i]` is high.
- `gnt` out `NUM_REQ`: one-hot, one-cycle acceptance pulse.
- `active_id` out `$clog2(NUM_REQ)`: index of the requester currently being transmitted.
- `busy` out 1: high while a frame is on the line.
- `frame_done` out 1: one-cycle pulse at the end of each stop bit.
- `tx` out 1: serial line, idle high.

## Operation
- The FSM has four states: IDLE, START, DATA, STOP. PARITY is added when parity is enabled.
- **Accept event:** `baud_tick` is high and `req` is non-zero, while in IDLE or on the final tick of STOP.
  - Winner is the first requester with `req` set, searching from `last+1` modulo `NUM_REQ`.
  - Latch the winner's slice into the shift register.
  - `last` ← winner; `active_id` ← winner.
  - `gnt[winner]` goes high for the next cycle only.
  - `tx` ← 0 and the FSM enters START.
- **START:** on `baud_tick`, `tx` ← `shift[0]`, bit counter ← 0, go to DATA.
- **DATA:** on each `baud_tick`, shift right (LSB first) and increment the counter.
  - After bit `DATA_W-1` has been held for one period, `tx` ← 1 and go to STOP.
- **STOP:** on `baud_tick`, pulse `frame_done`.
  - If `req` is non-zero, perform the accept event: back-to-back frame, no idle gap.
  - Otherwise go to IDLE.
- **IDLE:** `tx` = 1, `busy` = 0. A `baud_tick` with `req` = 0 does nothing.
- `busy` is high from the accepting edge through the stop-bit tick that does not re-accept.
- A `req` that rises mid-frame waits. A `req` dropped before `gnt` is a protocol violation; the block tolerates it by evaluating only the `req` sampled at the tick.
- Counters are plain binary. The bit counter is `$clog2(DATA_W)` bits wide and compared to `DATA_W-1`. There is no wrap beyond that value.

## Timing
- **Reset values:** `tx`=1, `gnt`=0, `busy`=0, `frame_done`=0, `active_id`=0, `last`=`NUM_REQ-1` (so requester 0 wins first), state IDLE.
- Reset assertion mid-frame forces `tx` high asynchronously and abandons the frame. No `gnt` or `frame_done` is produced.
- **Latency:** a `req` rising in IDLE is accepted on the next `baud_tick`, which is 1 to `BAUD_DIV` cycles later.
- `gnt` appears 1 cycle after the tick, coinciding with the first cycle of `tx`=0.
- **Frame length:** (`DATA_W`+2) bit periods, all edges aligned to `baud_tick`.
- `frame_done` and the next accept fall on the same tick; the next `gnt` follows 1 cycle later.
- All outputs are registered; there is no combinational path from `req` to `gnt`.

## Configuration
- **`UART_TX_PARITY_EN` defined:** a PARITY state is inserted between DATA and STOP.
  - `tx` carries even parity, i.e. the XOR of the latched payload, for one bit period.
  - Frame length becomes `DATA_W`+3 periods.
- **Undefined:** no parity state and no parity logic; frame length is `DATA_W`+2.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - Constants `UART_IDLE_LVL`=1 and `UART_START_LVL`=0.
  - Frame-length function of `DATA_W` and parity.
- **Sub-module `rr_arbiter`:**
  - Parameterised by `NUM_REQ`; inputs `req`, `last`; outputs one-hot `win` and index `win_id`.
  - Purely combinational. The scheduler owns the `last` register and the FSM.
- The baud-rate generator is instantiated by the parent, not inside this block.

## Test plan
- **Reset idle:** reset, then run 50 ticks with `req`=0. `tx` stays 1; `busy`, `gnt` and `frame_done` stay 0.
- **Single frame:** use `BAUD_DIV`=4 and set `req[2]` with `data` slice 2 = 0xA5.
  - `gnt`=0b0100 1 cycle after the tick.
  - `tx` sequence per tick is 0,1,0,1,0,0,1,0,1,1.
  - `frame_done` pulses once and `active_id`=2.
- **Round-robin fairness:** hold `req`=0b1111 continuously.
  - Grants arrive in order 0,1,2,3,0,… with no idle bit between frames.
  - Consecutive `gnt` pulses are exactly 10 ticks apart.
- **Late request:** raise `req[1]` mid-frame of requester 3 with `req[0]`=0. `req[1]` is granted on the stop tick of the current frame, before `req[0]` even if `req[0]` rises later.
- **Reset mid-frame:** assert `rst_n` low during DATA bit 4.
  - `tx`=1 immediately; no `gnt` or `frame_done` is produced.
  - After release, `req[0]` wins first.
- **Parity:** with `UART_TX_PARITY_EN` defined, send 0x07. The parity bit is 1, the frame is 11 ticks long, and the stop bit is 1.
